// File: rtl/rcv_field_ctrl.sv
// Receive field controller: counts de-stuffed bits into the active packet field,
// strips stuffed zeros, flags stuff violations and pulses field completion.
module rcv_field_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       shift_strobe,
  input  logic       d_orig,
  input  logic       eop,
  input  logic       sync_rcving,
  input  logic       pid_rcving,
  input  logic       crc5_rcving,
  input  logic       crc16_rcving,
  input  logic       data_rcving,
  output logic       sync_shift_enable,
  output logic       pid_shift_enable,
  output logic       crc5_shift_enable,
  output logic       crc16_shift_enable,
  output logic       data_shift_enable,
  output logic       sync_bits_received,
  output logic       pid_bits_received,
  output logic       crc5_bits_received,
  output logic       crc16_bits_received,
  output logic       data_bits_received,
  output logic [6:0] bit_count,
  output logic       rx_error,
  output logic [1:0] state_dbg
);

  // Handshake: shift_strobe is a one-cycle valid with no back-pressure; a bit is
  // consumed in the strobe cycle only when a *_shift_enable is high that cycle.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

  state_t     state_q, state_d;
  logic [4:0] field_q, field_d;   // one-hot latched field, 0 = none
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] ones_q, ones_d;
  logic       pulse_q, pulse_d;
  logic [4:0] shift_en;
  logic [4:0] rcving;
  logic       one_hot, multi, latched_active;
  logic [6:0] field_len;

  assign rcving = {data_rcving, crc16_rcving, crc5_rcving, pid_rcving, sync_rcving};
  assign one_hot = (rcving != 5'd0) && ((rcving & (rcving - 5'd1)) == 5'd0);
  assign multi = (rcving != 5'd0) && !one_hot;
  assign latched_active = |(rcving & field_q);

  always_comb begin
    field_len = 7'd0;
    case (field_q)
      5'b00001: field_len = 7'd8;
      5'b00010: field_len = 7'd8;
      5'b00100: field_len = 7'd5;
      5'b01000: field_len = 7'd16;
      5'b10000: field_len = 7'd64;
      default:  field_len = 7'd0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      field_q <= 5'd0;
      cnt_q   <= 7'd0;
      ones_q  <= 3'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    pulse_d  = 1'b0;
    shift_en = 5'd0;
    if (eop) begin
      state_d = IDLE;
      field_d = 5'd0;
      cnt_d   = 7'd0;
      ones_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (one_hot) begin
            field_d = rcving;
            cnt_d   = 7'd0;
            state_d = SHIFT;
          end else if (multi) begin
            state_d = ERR;
            ones_d  = 3'd0;
          end
        end
        SHIFT: begin
          if (!latched_active) begin
            state_d = IDLE;
            field_d = 5'd0;
            cnt_d   = 7'd0;
            ones_d  = 3'd0;
          end else if (shift_strobe) begin
            if (ones_q < 3'd6) begin
              shift_en = field_q;
              cnt_d    = cnt_q + 7'd1;
              ones_d   = d_orig ? ones_q + 3'd1 : 3'd0;
              if (cnt_q + 7'd1 == field_len) begin
                state_d = DONE;
                pulse_d = 1'b1;
              end
            end else if (!d_orig) begin
              ones_d = 3'd0;
            end else begin
              state_d = ERR;
              field_d = 5'd0;
              cnt_d   = 7'd0;
              ones_d  = 3'd0;
            end
          end
        end
        DONE: begin
          // ones_q is kept here so stuffing runs across adjacent fields
          if (!latched_active) begin
            if (one_hot) begin
              field_d = rcving;
              cnt_d   = 7'd0;
              state_d = SHIFT;
            end else if (multi) begin
              state_d = ERR;
              field_d = 5'd0;
              cnt_d   = 7'd0;
              ones_d  = 3'd0;
            end else begin
              state_d = IDLE;
              field_d = 5'd0;
              cnt_d   = 7'd0;
              ones_d  = 3'd0;
            end
          end
        end
        ERR: begin
          if (rcving == 5'd0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign {data_shift_enable, crc16_shift_enable, crc5_shift_enable,
          pid_shift_enable, sync_shift_enable} = shift_en;
  assign {data_bits_received, crc16_bits_received, crc5_bits_received,
          pid_bits_received, sync_bits_received} = (pulse_q && !eop) ? field_q : 5'd0;
  assign bit_count = cnt_q;
  assign rx_error  = (state_q == ERR);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rcv_field_ctrl.sv
// Randomised scoreboard bench for rcv_field_ctrl against a field-level model.
module tb_rcv_field_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       shift_strobe, d_orig, eop;
  logic [4:0] rcv;
  logic [4:0] en, brx;
  logic [6:0] bit_count;
  logic       rx_error;
  logic [1:0] state_dbg;

  int n_pass = 0;
  int n_total = 0;
  logic [4:0] exp_q[$];   // {kind[1:0], field[2:0]}: 01 enable, 10 done, 11 error

  int m_mode;   // 0 idle, 1 collecting, 2 field complete, 3 error
  int m_field, m_cnt, m_ones;
  logic prev_err = 1'b0;

  rcv_field_ctrl dut (
    .clk(clk), .n_rst(n_rst), .shift_strobe(shift_strobe), .d_orig(d_orig), .eop(eop),
    .sync_rcving(rcv[0]), .pid_rcving(rcv[1]), .crc5_rcving(rcv[2]),
    .crc16_rcving(rcv[3]), .data_rcving(rcv[4]),
    .sync_shift_enable(en[0]), .pid_shift_enable(en[1]), .crc5_shift_enable(en[2]),
    .crc16_shift_enable(en[3]), .data_shift_enable(en[4]),
    .sync_bits_received(brx[0]), .pid_bits_received(brx[1]), .crc5_bits_received(brx[2]),
    .crc16_bits_received(brx[3]), .data_bits_received(brx[4]),
    .bit_count(bit_count), .rx_error(rx_error), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic int flen(int f);
    case (f)
      0: return 8;
      1: return 8;
      2: return 5;
      3: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int first_idx(logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return 7;
  endfunction

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endfunction

  // reference model
  function automatic void model_idle_eval(logic [4:0] v);
    if ($countones(v) == 1) begin
      m_mode = 1; m_field = first_idx(v); m_cnt = 0;
    end else if ($countones(v) > 1) begin
      m_mode = 3; m_ones = 0; m_cnt = 0;
      exp_q.push_back(5'b11000);
    end
  endfunction

  function automatic void model_rcv(logic [4:0] v);
    case (m_mode)
      0: model_idle_eval(v);
      1: if (!v[m_field]) begin
           m_mode = 0; m_cnt = 0; m_ones = 0;
           model_idle_eval(v);
         end
      2: if (!v[m_field]) begin
           if ($countones(v) == 0) begin
             m_mode = 0; m_cnt = 0; m_ones = 0;
           end else if ($countones(v) == 1) begin
             m_mode = 1; m_field = first_idx(v); m_cnt = 0;
           end else begin
             m_mode = 3; m_cnt = 0; m_ones = 0;
             exp_q.push_back(5'b11000);
           end
         end
      default: if (v == 5'd0) m_mode = 0;
    endcase
  endfunction

  function automatic void model_strobe(bit b);
    if (m_mode != 1) return;
    if (m_ones < 6) begin
      exp_q.push_back({2'b01, 3'(m_field)});
      m_cnt++;
      m_ones = b ? m_ones + 1 : 0;
      if (m_cnt == flen(m_field)) begin
        m_mode = 2;
        exp_q.push_back({2'b10, 3'(m_field)});
      end
    end else if (!b) begin
      m_ones = 0;
    end else begin
      m_mode = 3; m_cnt = 0; m_ones = 0;
      exp_q.push_back(5'b11000);
    end
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents an event
  task automatic pop_cmp(string name, logic [4:0] got);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_%s actual=%0h expected=none at %0t", name, got, $time);
    end else begin
      check(name, got, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (en != 5'd0 || brx != 5'd0)
        check("one_hot_outputs", int'($countones(en) <= 1 && $countones(brx) <= 1), 1);
      if (en != 5'd0) pop_cmp("shift_enable", {2'b01, 3'(first_idx(en))});
      if (brx != 5'd0) pop_cmp("bits_received", {2'b10, 3'(first_idx(brx))});
      if (rx_error && !prev_err) pop_cmp("rx_error", 5'b11000);
      prev_err = rx_error;
    end else begin
      prev_err = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_strobe(bit b);
    shift_strobe = 1'b1;
    d_orig = b;
    model_strobe(b);
    tick();
    shift_strobe = 1'b0;
    d_orig = 1'($urandom_range(0, 1));
    repeat ($urandom_range(3, 4)) tick();
  endtask

  task automatic set_rcv(logic [4:0] v);
    rcv = v;
    model_rcv(v);
    tick();
    tick();
    tick();
  endtask

  task automatic do_eop(bit with_strobe);
    eop = 1'b1;
    shift_strobe = with_strobe;
    d_orig = 1'($urandom_range(0, 1));
    m_mode = 0; m_cnt = 0; m_ones = 0;
    tick();
    eop = 1'b0;
    shift_strobe = 1'b0;
    check("eop_bit_count", int'(bit_count), 0);
    model_rcv(rcv);
    repeat (3) tick();
  endtask

  task automatic chk_cnt(string name);
    if (m_mode == 1 || m_mode == 2) check(name, int'(bit_count), m_cnt);
  endtask

  task automatic apply_reset();
    #2 n_rst = 1'b0;
    #1;
    check("reset_outputs", int'({en, brx, rx_error}), 0);
    check("reset_bit_count", int'(bit_count), 0);
    tick();
    tick();
    n_rst = 1'b1;
    exp_q.delete();
    m_mode = 0; m_cnt = 0; m_ones = 0; m_field = 0;
    model_rcv(rcv);
    tick();
    tick();
  endtask

  // bit that never forms a stuff violation
  function automatic bit safe_bit();
    if (m_ones == 6) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    n_rst = 1'b0; shift_strobe = 1'b0; d_orig = 1'b0; eop = 1'b0; rcv = 5'd0;
    m_mode = 0; m_cnt = 0; m_ones = 0; m_field = 0;
    tick();
    apply_reset();

    // sync: 0000_0001
    set_rcv(5'b00001);
    for (int i = 0; i < 8; i++) do_strobe(i == 7);
    check("sync_bit_count", int'(bit_count), 8);
    set_rcv(5'b00000);

    // pid with one stuffed zero
    set_rcv(5'b00010);
    for (int i = 0; i < 9; i++) do_strobe(i != 6);
    check("pid_bit_count", int'(bit_count), 8);
    set_rcv(5'b00000);

    // crc5 with seven ones, then crc16 with seven ones (stuff violation)
    set_rcv(5'b00100);
    for (int i = 0; i < 7; i++) do_strobe(1'b1);
    chk_cnt("crc5_bit_count");
    set_rcv(5'b00000);
    set_rcv(5'b01000);
    for (int i = 0; i < 7; i++) do_strobe(1'b1);
    check("violation_rx_error", int'(rx_error), 1);
    set_rcv(5'b00000);
    check("err_exit_rx_error", int'(rx_error), 0);

    // data interrupted by eop on the 30th strobe
    set_rcv(5'b10000);
    for (int i = 0; i < 29; i++) do_strobe(i % 3 != 0);
    chk_cnt("data_29_bit_count");
    do_eop(1'b1);
    set_rcv(5'b00000);

    // two fields selected at once
    set_rcv(5'b00011);
    check("multi_rx_error", int'(rx_error), 1);
    do_strobe(1'b1);
    set_rcv(5'b00000);

    // reset after 40 data bits, data_rcving still high
    set_rcv(5'b10000);
    for (int i = 0; i < 40; i++) do_strobe(safe_bit());
    chk_cnt("data_40_bit_count");
    apply_reset();
    check("post_reset_bit_count", int'(bit_count), 0);
    while (m_mode == 1) do_strobe(safe_bit());
    check("post_reset_data_count", int'(bit_count), 64);
    set_rcv(5'b00000);

    // randomised fields, chaining, aborts, eop and violations
    for (int it = 0; it < 25; it++) begin
      int f, g, n;
      f = $urandom_range(0, 4);
      set_rcv(5'(1 << f));
      n = 0;
      while (m_mode == 1 && n < 80) begin
        if ($urandom_range(0, 60) == 0) do_eop($urandom_range(0, 1) == 1);
        else if ($urandom_range(0, 15) == 0) do_strobe(1'b1);
        else do_strobe(safe_bit());
        n++;
        if ($urandom_range(0, 40) == 0 && m_mode == 1) set_rcv(5'd0);
      end
      chk_cnt("rand_bit_count");
      if (m_mode == 2) begin
        do_strobe(1'($urandom_range(0, 1)));
        chk_cnt("done_hold_bit_count");
        if ($urandom_range(0, 1) == 1) begin
          g = (f + $urandom_range(1, 4)) % 5;
          set_rcv(5'(1 << g));
          for (int k = 0; k < 10 && m_mode == 1; k++) do_strobe(safe_bit());
          chk_cnt("chain_bit_count");
        end
      end
      check("rand_rx_error", int'(rx_error), int'(m_mode == 3));
      set_rcv(5'd0);
    end

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
